irig_frame_sync: RTL and testbench
==================================

# irig_frame_sync

Frame-level controller for the IRIG-B00x receive path. It consumes the 0/1/marker symbol stream from the pulse-width bit parser and finds frame alignment from the double-marker pattern (P0 followed by Pr). It then tracks the 100-symbol frame position, checks every position marker and extracts the BCD time fields. Downstream time-keeping logic uses its `locked`, `pps` and `frame_valid` outputs.

## Interface
- `TIMEOUT`, default 100000000: clk cycles without a symbol before lock is dropped (about 1 s at 100 MHz).
- `ERR_W`, default 16: width of the saturating error counter.
- `clk`  in  1  system clock.
- `rst`  in  1  reset; asynchronous and active-high.
- `sym`  in  2  symbol code: 0 = zero, 1 = one, 2 = marker, 3 = illegal.
- `sym_valid`  in  1  one-cycle strobe; `sym` is sampled only when this is high.
- `locked`  out  1  high while frame alignment is held.
- `pps`  out  1  one-cycle pulse on the accepted Pr (index 0) symbol while locked.
- `frame_valid`  out  1  one-cycle pulse; the time fields below updated on this cycle.
- `frame_err`  out  1  one-cycle pulse on each alignment violation.
- `err_count`  out  ERR_W  count of `frame_err` events; saturates at all-ones.
- `sec_bcd`  out  7  seconds {tens[2:0], units[3:0]}.
- `min_bcd`  out  7  minutes {tens[2:0], units[3:0]}.
- `hour_bcd`  out  6  hours {tens[1:0], units[3:0]}.
- `day_bcd`  out  10  day of year {hundreds[1:0], tens[3:0], units[3:0]}.
- `year_bcd`  out  8  year {tens[3:0], units[3:0]}.

## Operation
- States:
  - SEARCH: wait for a marker.
  - GOT_P0: one marker seen; a second marker is expected.
  - FRAME: aligned; frame index `idx` runs 0..99.
- SEARCH + marker → GOT_P0. Any other symbol keeps SEARCH.
- GOT_P0 + marker → FRAME. This marker is Pr: `idx` = 0, and the next symbol is `idx` 1. Any other symbol → SEARCH, with no error.
- FRAME, on each `sym_valid`:
  - Marker positions are {0,9,19,29,39,49,59,69,79,89,99}.
  - A marker at a marker position, or a 0/1 at any other position, is accepted. `idx` increments and wraps 99→0.
  - Any mismatch, or `sym`=3, is an error: pulse `frame_err`, increment `err_count`, clear `locked`, go to SEARCH.
  - Data symbols at `idx` 1..98 shift into a 98-bit capture register at position `idx`.
- Field bits, LSB first within each digit:
  - sec: units 1-4, tens 6-8.
  - min: units 10-13, tens 15-17.
  - hour: units 20-23, tens 25-26.
  - day: units 30-33, tens 35-38, hundreds 40-41.
  - year: units 50-53, tens 55-58.
  - All other data bits are captured but not output.
- Publish happens on the accepted marker at `idx` 99 (P0):
  - All fields load from the capture register.
  - `frame_valid` pulses and `locked` is set.
- The first publish after entering FRAME requires the full run idx 0→99. A partial frame never publishes.
- Watchdog:
  - The counter clears on every `sym_valid` and increments otherwise.
  - When it reaches `TIMEOUT`: clear `locked`, go to SEARCH, no `frame_err`.
  - The watchdog is active in every state except SEARCH.
- Fields hold their last published value after lock loss. They change only on `frame_valid`.

## Timing
- Reset values: all outputs 0, state SEARCH, `idx` 0, capture register 0, watchdog 0.
- Latency: `frame_valid`, `pps`, `frame_err` and the field updates are registered. Each asserts exactly one clk after the `sym_valid` cycle that causes it.
- `pps` marks the end of the Pr pulse, because the parser strobes at the falling edge. The fixed offset is the marker width and is not compensated here.
- Same cycle as `sym_valid` and watchdog reaching `TIMEOUT`: `sym_valid` wins. The symbol is processed and the watchdog clears.
- Back-to-back `sym_valid` on consecutive clk cycles must be accepted, with no bubble required.
- `err_count` at all-ones stays at all-ones; `frame_err` still pulses.
- `rst` asserted mid-frame: immediate return to reset values. Fields also clear.

## Structure
- Shared package/include `irig_pkg`:
  - Symbol codes `SYM_ZERO`, `SYM_ONE`, `SYM_MARK`.
  - `FRAME_LEN`=100.
  - The marker-position set.
  - The field bit-position constants.
- One sub-module, `irig_watchdog`: a parameterised timeout counter with `kick` input and one-cycle `expired` output.
- Marker-position check and field extraction are combinational inside `irig_frame_sync`.

## Test plan
- Two markers, then 98 valid symbols encoding 12:34:56 on day 123 of year 24, then a P0 marker → one clk later `frame_valid`=1, `locked`=1, `sec_bcd`=7'h56, `min_bcd`=7'h34, `hour_bcd`=6'h12, `day_bcd`=10'h123, `year_bcd`=8'h24.
- Locked, second frame → `pps` pulses one clk after the Pr strobe; fields update to the new values only at the next P0.
- Locked, a `1` sent at `idx` 19 → `frame_err` pulse, `err_count`=1, `locked`=0, state SEARCH, fields unchanged.
- `TIMEOUT`=1000, locked, `sym_valid` withheld for 1000 clk → `locked`=0, `frame_err`=0; re-acquisition needs a full frame.
- `ERR_W`=2, five errors forced → `err_count` sticks at 3, five `frame_err` pulses.
- `rst` pulsed at `idx` 50 → all outputs 0 immediately; the next P0+Pr+frame locks normally.

Source files
------------

// File: rtl/irig_pkg.sv
// irig_pkg: shared symbol codes, frame geometry, marker set and BCD field bit positions for the IRIG-B frame path
package irig_pkg;
  typedef enum logic [1:0] {SEARCH, GOT_P0, FRAME} state_t;
  localparam logic [1:0] SYM_ZERO = 2'd0;
  localparam logic [1:0] SYM_ONE  = 2'd1;
  localparam logic [1:0] SYM_MARK = 2'd2;
  localparam int FRAME_LEN = 100;
  localparam int IDX_W = 7;
  localparam int N_MARK = 11;
  localparam int MARK_POS [N_MARK] = '{0, 9, 19, 29, 39, 49, 59, 69, 79, 89, 99};
  localparam int SEC_U  = 1;
  localparam int SEC_T  = 6;
  localparam int MIN_U  = 10;
  localparam int MIN_T  = 15;
  localparam int HOUR_U = 20;
  localparam int HOUR_T = 25;
  localparam int DAY_U  = 30;
  localparam int DAY_T  = 35;
  localparam int DAY_H  = 40;
  localparam int YEAR_U = 50;
  localparam int YEAR_T = 55;
  function automatic logic is_mark(input logic [IDX_W-1:0] i);
    logic m = 1'b0;
    for (int k = 0; k < N_MARK; k++) m |= (i == IDX_W'(MARK_POS[k]));
    return m;
  endfunction
endpackage

// File: rtl/irig_frame_sync_if.sv
// irig_frame_sync_if: symbol stream from the pulse-width parser
//   sym        2-bit symbol code (zero/one/marker/illegal)
//   sym_valid  one-cycle strobe qualifying sym
interface irig_frame_sync_if;
  logic [1:0] sym;
  logic       sym_valid;
  modport master (output sym, sym_valid);
  modport slave  (input  sym, sym_valid);
endinterface

// File: rtl/irig_watchdog.sv
// irig_watchdog: counts clk cycles since the last kick, pulses expired for one cycle at TIMEOUT
//   clk, rst  clock and async active-high reset
//   kick      clears the count (a kick on the expiry cycle suppresses expiry)
//   expired   one-cycle pulse when TIMEOUT idle cycles have elapsed
module irig_watchdog #(
  parameter int TIMEOUT = 100000000
) (
  input  logic clk,
  input  logic rst,
  input  logic kick,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT + 1);
  logic [W-1:0] cnt;
  assign expired = !kick && cnt == W'(TIMEOUT);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else cnt <= (kick || expired) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/irig_frame_sync.sv
// irig_frame_sync: IRIG-B frame alignment, marker checking and BCD time extraction
//   clk, rst     clock and async active-high reset
//   bus          symbol stream (sym, sym_valid)
//   locked       frame alignment held
//   pps          pulse on the accepted Pr while locked
//   frame_valid  pulse when the time fields update
//   frame_err    pulse on each alignment violation; err_count saturates
//   *_bcd        last published time fields
module irig_frame_sync
  import irig_pkg::*;
#(
  parameter int TIMEOUT = 100000000,
  parameter int ERR_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  irig_frame_sync_if.slave     bus,
  output logic                 locked,
  output logic                 pps,
  output logic                 frame_valid,
  output logic                 frame_err,
  output logic [ERR_W-1:0]     err_count,
  output logic [6:0]           sec_bcd,
  output logic [6:0]           min_bcd,
  output logic [5:0]           hour_bcd,
  output logic [9:0]           day_bcd,
  output logic [7:0]           year_bcd
);
  state_t state, state_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic [98:1] cap;
  logic locked_n, pps_n, fv_n, fe_n, wr, expired, mpos, ok;
  logic [6:0] sec_n, min_n;
  logic [5:0] hour_n;
  logic [9:0] day_n;
  logic [7:0] year_n;
  irig_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk(clk),
    .rst(rst),
    .kick(bus.sym_valid || state == SEARCH),
    .expired(expired)
  );
  always_comb begin
    mpos = is_mark(idx);
    ok = bus.sym == SYM_MARK ? mpos : (!bus.sym[1] && !mpos);
    state_n = state;
    idx_n = idx;
    locked_n = locked;
    pps_n = 1'b0;
    fv_n = 1'b0;
    fe_n = 1'b0;
    wr = 1'b0;
    sec_n = {cap[SEC_T +: 3], cap[SEC_U +: 4]};
    min_n = {cap[MIN_T +: 3], cap[MIN_U +: 4]};
    hour_n = {cap[HOUR_T +: 2], cap[HOUR_U +: 4]};
    day_n = {cap[DAY_H +: 2], cap[DAY_T +: 4], cap[DAY_U +: 4]};
    year_n = {cap[YEAR_T +: 4], cap[YEAR_U +: 4]};
    if (bus.sym_valid) begin
      unique case (state)
        SEARCH: state_n = bus.sym == SYM_MARK ? GOT_P0 : SEARCH;
        GOT_P0: begin
          // the second marker is Pr, so the following symbol sits at idx 1
          state_n = bus.sym == SYM_MARK ? FRAME : SEARCH;
          idx_n = IDX_W'(1);
        end
        FRAME: begin
          if (!ok) begin
            fe_n = 1'b1;
            locked_n = 1'b0;
            state_n = SEARCH;
          end else begin
            idx_n = idx == IDX_W'(FRAME_LEN - 1) ? '0 : idx + 1'b1;
            // accepted data can only land on idx 1..98 since 0 and 99 are markers
            wr = bus.sym != SYM_MARK;
            pps_n = idx == '0 && locked;
            fv_n = idx == IDX_W'(FRAME_LEN - 1);
            locked_n = locked || fv_n;
          end
        end
        default: state_n = SEARCH;
      endcase
    end else if (expired) begin
      state_n = SEARCH;
      locked_n = 1'b0;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= SEARCH;
      idx <= '0;
      cap <= '0;
      locked <= 1'b0;
      pps <= 1'b0;
      frame_valid <= 1'b0;
      frame_err <= 1'b0;
      err_count <= '0;
      sec_bcd <= '0;
      min_bcd <= '0;
      hour_bcd <= '0;
      day_bcd <= '0;
      year_bcd <= '0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      locked <= locked_n;
      pps <= pps_n;
      frame_valid <= fv_n;
      frame_err <= fe_n;
      err_count <= (fe_n && !(&err_count)) ? err_count + 1'b1 : err_count;
      if (wr) cap[idx] <= bus.sym[0];
      if (fv_n) begin
        sec_bcd <= sec_n;
        min_bcd <= min_n;
        hour_bcd <= hour_n;
        day_bcd <= day_n;
        year_bcd <= year_n;
      end
    end
endmodule

// File: tb/tb_irig_frame_sync.sv
// tb_irig_frame_sync: scoreboard bench for irig_frame_sync
module tb_irig_frame_sync;
  typedef struct packed {
    logic fv, pps, fe, lk;
    logic [15:0] ec;
    logic [1:0] ec2;
    logic [6:0] s, m;
    logic [5:0] h;
    logic [9:0] d;
    logic [7:0] y;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  irig_frame_sync_if bus();
  logic locked, pps, frame_valid, frame_err;
  logic [15:0] err_count;
  logic [6:0] sec_bcd, min_bcd;
  logic [5:0] hour_bcd;
  logic [9:0] day_bcd;
  logic [7:0] year_bcd;
  logic locked2, pps2, frame_valid2, frame_err2;
  logic [1:0] err_count2;
  logic [6:0] sec2, min2;
  logic [5:0] hour2;
  logic [9:0] day2;
  logic [7:0] year2;
  irig_frame_sync #(.TIMEOUT(1000), .ERR_W(16)) dut (
    .clk(clk), .rst(rst), .bus(bus), .locked(locked), .pps(pps), .frame_valid(frame_valid),
    .frame_err(frame_err), .err_count(err_count), .sec_bcd(sec_bcd), .min_bcd(min_bcd),
    .hour_bcd(hour_bcd), .day_bcd(day_bcd), .year_bcd(year_bcd));
  irig_frame_sync #(.TIMEOUT(1000), .ERR_W(2)) dut2 (
    .clk(clk), .rst(rst), .bus(bus), .locked(locked2), .pps(pps2), .frame_valid(frame_valid2),
    .frame_err(frame_err2), .err_count(err_count2), .sec_bcd(sec2), .min_bcd(min2),
    .hour_bcd(hour2), .day_bcd(day2), .year_bcd(year2));
  int n_tests = 0, n_fail = 0;
  exp_t sb[$];
  exp_t ce;
  logic [1:0] fr [100];
  logic mcap [100];
  int mst, midx, merr;
  logic mlk;
  logic [6:0] ms_s, ms_m;
  logic [5:0] ms_h;
  logic [9:0] ms_d;
  logic [7:0] ms_y;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic is_mpos(int i);
    return (i % 10 == 9) || (i == 0);
  endfunction
  function automatic logic [9:0] gb(int p, int n);
    logic [9:0] v = '0;
    for (int i = 0; i < n; i++) v[i] = mcap[p + i];
    return v;
  endfunction
  task automatic model_reset();
    mst = 0; midx = 0; mlk = 1'b0; merr = 0;
    for (int i = 0; i < 100; i++) mcap[i] = 1'b0;
    ms_s = '0; ms_m = '0; ms_h = '0; ms_d = '0; ms_y = '0;
  endtask
  task automatic step(input logic [1:0] s, output exp_t e);
    logic ok, mp;
    e = '0;
    case (mst)
      0: if (s == 2'd2) mst = 1;
      1: begin
        if (s == 2'd2) begin mst = 2; midx = 1; end
        else mst = 0;
      end
      default: begin
        mp = is_mpos(midx);
        ok = (s == 2'd2) ? mp : (s < 2'd2 && !mp);
        if (!ok) begin
          e.fe = 1'b1; merr++; mlk = 1'b0; mst = 0;
        end else begin
          if (s < 2'd2) mcap[midx] = s[0];
          if (midx == 0 && mlk) e.pps = 1'b1;
          if (midx == 99) begin
            ms_s = 7'((gb(6, 3) << 4) | gb(1, 4));
            ms_m = 7'((gb(15, 3) << 4) | gb(10, 4));
            ms_h = 6'((gb(25, 2) << 4) | gb(20, 4));
            ms_d = 10'((gb(40, 2) << 8) | (gb(35, 4) << 4) | gb(30, 4));
            ms_y = 8'((gb(55, 4) << 4) | gb(50, 4));
            e.fv = 1'b1; mlk = 1'b1;
          end
          midx = (midx == 99) ? 0 : midx + 1;
        end
      end
    endcase
    e.lk = mlk; e.ec = 16'(merr); e.ec2 = merr > 3 ? 2'd3 : 2'(merr);
    e.s = ms_s; e.m = ms_m; e.h = ms_h; e.d = ms_d; e.y = ms_y;
  endtask
  task automatic build(input logic [6:0] s, input logic [6:0] m, input logic [5:0] h,
                       input logic [9:0] d, input logic [7:0] y);
    for (int i = 0; i < 100; i++) fr[i] = is_mpos(i) ? 2'd2 : 2'($urandom_range(0, 1));
    for (int i = 0; i < 4; i++) begin
      fr[1 + i] = {1'b0, s[i]}; fr[10 + i] = {1'b0, m[i]}; fr[20 + i] = {1'b0, h[i]};
      fr[30 + i] = {1'b0, d[i]}; fr[35 + i] = {1'b0, d[4 + i]};
      fr[50 + i] = {1'b0, y[i]}; fr[55 + i] = {1'b0, y[4 + i]};
    end
    for (int i = 0; i < 3; i++) begin fr[6 + i] = {1'b0, s[4 + i]}; fr[15 + i] = {1'b0, m[4 + i]}; end
    for (int i = 0; i < 2; i++) begin fr[25 + i] = {1'b0, h[4 + i]}; fr[40 + i] = {1'b0, d[8 + i]}; end
  endtask
  task automatic idle(input int n);
    repeat (n) begin @(negedge clk); bus.sym_valid = 1'b0; end
  endtask
  task automatic send(input logic [1:0] s);
    exp_t e;
    @(negedge clk);
    bus.sym = s; bus.sym_valid = 1'b1;
    step(s, e);
    sb.push_back(e);
  endtask
  task automatic send_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      send(fr[i]);
      if ($urandom_range(0, 7) == 0) idle(1);
    end
  endtask
  task automatic check_fields(input string tag, input logic [6:0] s, input logic [6:0] m,
                              input logic [5:0] h, input logic [9:0] d, input logic [7:0] y);
    check({tag, "_sec"}, sec_bcd, s); check({tag, "_min"}, min_bcd, m); check({tag, "_hour"}, hour_bcd, h);
    check({tag, "_day"}, day_bcd, d); check({tag, "_year"}, year_bcd, y);
  endtask
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      ce = sb.pop_front();
      check("sb_fv", frame_valid, ce.fv); check("sb_pps", pps, ce.pps); check("sb_fe", frame_err, ce.fe);
      check("sb_locked", locked, ce.lk); check("sb_errc", err_count, ce.ec);
      check("sb_fe2", frame_err2, ce.fe); check("sb_errc2", err_count2, ce.ec2);
      check("sb_sec", sec_bcd, ce.s); check("sb_min", min_bcd, ce.m); check("sb_hour", hour_bcd, ce.h);
      check("sb_day", day_bcd, ce.d); check("sb_year", year_bcd, ce.y);
    end
  end
  initial begin
    logic seen;
    bus.sym = 2'd0; bus.sym_valid = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_locked", locked, 0); check("rst_fv", frame_valid, 0); check("rst_pps", pps, 0);
    check("rst_fe", frame_err, 0); check("rst_errc", err_count, 0);
    check_fields("rst", 0, 0, 0, 0, 0);
    rst = 1'b0;
    send(2'd2); send(2'd0);
    send(2'd2);
    build(7'h56, 7'h34, 6'h12, 10'h123, 8'h24);
    send_range(0, 99);
    idle(1);
    check("f1_fv", frame_valid, 1); check("f1_locked", locked, 1);
    check_fields("f1", 7'h56, 7'h34, 6'h12, 10'h123, 8'h24);
    build(7'h57, 7'h34, 6'h12, 10'h123, 8'h24);
    send(fr[0]);
    idle(1);
    check("f2_pps", pps, 1);
    send_range(1, 60);
    idle(1);
    check_fields("f2_mid", 7'h56, 7'h34, 6'h12, 10'h123, 8'h24);
    send_range(61, 99);
    idle(1);
    check_fields("f2", 7'h57, 7'h34, 6'h12, 10'h123, 8'h24);
    build(7'h58, 7'h35, 6'h13, 10'h124, 8'h25);
    send_range(0, 18);
    send(2'd1);
    idle(1);
    check("e19_fe", frame_err, 1); check("e19_errc", err_count, 1); check("e19_locked", locked, 0);
    check_fields("e19", 7'h57, 7'h34, 6'h12, 10'h123, 8'h24);
    send(2'd2);
    build(7'h59, 7'h59, 6'h23, 10'h366, 8'h99);
    send_range(0, 99);
    idle(1);
    check("f3_locked", locked, 1);
    seen = 1'b0;
    repeat (990) begin @(negedge clk); if (frame_err) seen = 1'b1; end
    check("wd_early_locked", locked, 1);
    repeat (20) begin @(negedge clk); if (frame_err) seen = 1'b1; end
    check("wd_locked", locked, 0); check("wd_no_fe", seen, 0);
    check_fields("wd", 7'h59, 7'h59, 6'h23, 10'h366, 8'h99);
    mst = 0; mlk = 1'b0;
    send(2'd2);
    build(7'h00, 7'h00, 6'h00, 10'h001, 8'h25);
    send_range(0, 49);
    idle(1);
    check("part_locked", locked, 0);
    send_range(50, 99);
    idle(1);
    check("f4_locked", locked, 1);
    check_fields("f4", 7'h00, 7'h00, 6'h00, 10'h001, 8'h25);
    send(2'd3);
    for (int k = 0; k < 5; k++) begin
      send(2'd2); send(2'd2); send(k % 2 ? 2'd3 : 2'd2);
      idle(1);
      check("sat_fe", frame_err, 1); check("sat_fe2", frame_err2, 1);
    end
    check("sat_errc", err_count, 7); check("sat_errc2", err_count2, 3);
    send(2'd2);
    build(7'h11, 7'h22, 6'h03, 10'h200, 8'h30);
    send_range(0, 99);
    build(7'h12, 7'h22, 6'h03, 10'h200, 8'h30);
    send_range(0, 50);
    @(negedge clk);
    bus.sym_valid = 1'b0; rst = 1'b1;
    #1;
    check("mrst_locked", locked, 0); check("mrst_fv", frame_valid, 0); check("mrst_pps", pps, 0);
    check("mrst_fe", frame_err, 0); check("mrst_errc", err_count, 0); check("mrst_errc2", err_count2, 0);
    check_fields("mrst", 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    send(2'd2);
    build(7'h42, 7'h17, 6'h09, 10'h045, 8'h26);
    send_range(0, 99);
    idle(1);
    check("f7_locked", locked, 1); check("f7_fv", frame_valid, 1);
    check_fields("f7", 7'h42, 7'h17, 6'h09, 10'h045, 8'h26);
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    check("sb_drain", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
